// File: rtl/clarvi_mem_arbiter.sv
// Two-port Avalon-MM arbiter sharing one fixed-latency memory slave between CPU data (main) and instruction ports.
// Define CLARVI_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; otherwise main has fixed priority.
module clarvi_mem_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] avs_main_address,
  input  logic [3:0]            avs_main_byteenable,
  input  logic                  avs_main_read,
  input  logic                  avs_main_write,
  input  logic [31:0]           avs_main_writedata,
  output logic [31:0]           avs_main_readdata,
  output logic                  avs_main_waitrequest,
  output logic                  avs_main_readdatavalid,
  input  logic [ADDR_WIDTH-1:0] avs_instr_address,
  input  logic                  avs_instr_read,
  output logic [31:0]           avs_instr_readdata,
  output logic                  avs_instr_waitrequest,
  output logic                  avs_instr_readdatavalid,
  output logic [ADDR_WIDTH-1:0] avm_mem_address,
  output logic [3:0]            avm_mem_byteenable,
  output logic                  avm_mem_read,
  output logic                  avm_mem_write,
  output logic [31:0]           avm_mem_writedata,
  input  logic [31:0]           avm_mem_readdata,
  input  logic                  avm_mem_waitrequest,
  input  logic                  avm_mem_readdatavalid,
  output logic                  rsp_orphan
);

  localparam logic OWNER_MAIN  = 1'b1;
  localparam logic OWNER_INSTR = 1'b0;

  logic req_m_s;
  logic req_i_s;
  logic grant_main_s;
  logic grant_any_s;
  logic accept_s;
  logic accept_read_s;
  logic hold_valid_r;
  logic hold_owner_r;
  logic hold_req_s;
  logic [READ_LATENCY-1:0] pipe_valid_r;
  logic [READ_LATENCY-1:0] pipe_owner_r;
  logic tail_valid_s;
  logic tail_owner_s;
  logic rsp_orphan_r;
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
  logic last_grant_r;
`endif

  // Request decode and grant selection; a stalled winner keeps the bus until its transfer is accepted.
  always_comb begin
    req_m_s      = avs_main_read | avs_main_write;
    req_i_s      = avs_instr_read;
    grant_any_s  = req_m_s | req_i_s;
    hold_req_s   = (hold_owner_r == OWNER_MAIN) ? req_m_s : req_i_s;
    grant_main_s = 1'b0;
    if (hold_valid_r && hold_req_s) begin
      grant_main_s = hold_owner_r;
    end else if (req_m_s && req_i_s) begin
`ifdef CLARVI_ARB_ROUND_ROBIN_EN
      grant_main_s = (last_grant_r == OWNER_INSTR);
`else
      grant_main_s = 1'b1;
`endif
    end else begin
      grant_main_s = req_m_s;
    end
    accept_s      = grant_any_s & ~avm_mem_waitrequest;
    accept_read_s = accept_s & (grant_main_s ? avs_main_read : avs_instr_read);
  end

  // Command mux onto the memory port and per-port stall generation.
  always_comb begin
    avm_mem_writedata = avs_main_writedata;
    if (grant_main_s) begin
      avm_mem_address    = avs_main_address;
      avm_mem_byteenable = avs_main_byteenable;
      avm_mem_read       = avs_main_read & ~reset;
      avm_mem_write      = avs_main_write & ~reset;
    end else begin
      avm_mem_address    = avs_instr_address;
      avm_mem_byteenable = 4'hF;
      avm_mem_read       = avs_instr_read & ~reset;
      avm_mem_write      = 1'b0;
    end
    if (!req_m_s) begin
      avs_main_waitrequest = 1'b0;
    end else if (grant_main_s) begin
      avs_main_waitrequest = avm_mem_waitrequest;
    end else begin
      avs_main_waitrequest = 1'b1;
    end
    if (!req_i_s) begin
      avs_instr_waitrequest = 1'b0;
    end else if (!grant_main_s) begin
      avs_instr_waitrequest = avm_mem_waitrequest;
    end else begin
      avs_instr_waitrequest = 1'b1;
    end
  end

  // Remember a stalled grant so the winner cannot be pre-empted mid-transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid_r <= 1'b0;
      hold_owner_r <= OWNER_INSTR;
    end else begin
      hold_valid_r <= grant_any_s & avm_mem_waitrequest;
      hold_owner_r <= grant_main_s;
    end
  end

`ifdef CLARVI_ARB_ROUND_ROBIN_EN
  // Owner of the most recent accepted transfer, used to alternate on conflict.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_r <= OWNER_INSTR;
    end else if (accept_s) begin
      last_grant_r <= grant_main_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Ownership pipe: one stage per cycle of slave read latency; writes enter as invalid slots.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_valid_r <= '0;
      pipe_owner_r <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_owner_r[i] <= pipe_owner_r[i-1];
      end
      pipe_valid_r[0] <= accept_read_s;
      pipe_owner_r[0] <= grant_main_s;
    end
  end

  assign tail_valid_s = pipe_valid_r[READ_LATENCY-1];
  assign tail_owner_s = pipe_owner_r[READ_LATENCY-1];

  // Sticky flag for read data that arrives with no pending read to claim it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_orphan_r <= 1'b0;
    end else if (avm_mem_readdatavalid && !tail_valid_s) begin
      rsp_orphan_r <= 1'b1;
    end else begin
      rsp_orphan_r <= rsp_orphan_r;
    end
  end

  assign rsp_orphan              = rsp_orphan_r;
  assign avs_main_readdata       = avm_mem_readdata;
  assign avs_instr_readdata      = avm_mem_readdata;
  assign avs_main_readdatavalid  = avm_mem_readdatavalid & tail_valid_s & (tail_owner_s == OWNER_MAIN);
  assign avs_instr_readdatavalid = avm_mem_readdatavalid & tail_valid_s & (tail_owner_s == OWNER_INSTR);

endmodule
